batch_assembler: RTL and testbench

BATCH_ASSEMBLER -- requirements
Module: batch_assembler

---
 rtl/svm_sched_pkg.sv | 22 ++
 rtl/batch_buffer.sv | 27 ++
 rtl/batch_assembler.sv | 151 +++++++++++++++
 tb/tb_batch_assembler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_sched_pkg.sv
// Shared types for the SVM scheduler: transaction record and batch FSM encodings.
package svm_sched_pkg;

    localparam int unsigned PID_WIDTH = 64;
    localparam int unsigned DEP_WIDTH = 1024;

    typedef struct packed {
        logic [PID_WIDTH-1:0] programID;
        logic [DEP_WIDTH-1:0] read_deps;
        logic [DEP_WIDTH-1:0] write_deps;
    } txn_t;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Address width for an n-entry array, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/batch_buffer.sv
// Batch storage: DEPTH-entry register array, one write port, one combinational read port.
module batch_buffer
    import svm_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  txn_t          wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output txn_t          rd_data_o
);

    txn_t mem_q [DEPTH];

    // Capture an accepted transaction into its slot; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/batch_assembler.sv
// Groups conflict-free transactions into batches, closed when full or on timeout,
// then drains them in acceptance order with tlast on the final beat.
module batch_assembler
    import svm_sched_pkg::*;
#(
    parameter int unsigned MAX_BATCH_SIZE = 8,
    parameter int unsigned BATCH_TIMEOUT  = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [PID_WIDTH-1:0] s_axis_tdata_owner_programID,
    input  logic [DEP_WIDTH-1:0] s_axis_tdata_read_dependencies,
    input  logic [DEP_WIDTH-1:0] s_axis_tdata_write_dependencies,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [PID_WIDTH-1:0] m_axis_tdata_owner_programID,
    output logic [DEP_WIDTH-1:0] m_axis_tdata_read_dependencies,
    output logic [DEP_WIDTH-1:0] m_axis_tdata_write_dependencies,
    output logic                 m_axis_tlast,
    output logic                 batch_completed,
    output logic [7:0]           batch_fill,
    output logic [31:0]          batches_issued,
    output logic [31:0]          timeout_closes,
    output logic [31:0]          txns_issued
);

    localparam int unsigned AW    = addr_w(MAX_BATCH_SIZE);
    localparam logic [7:0]  MAX_C = 8'(MAX_BATCH_SIZE);
    localparam logic [15:0] TMO_C = 16'(BATCH_TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0] timer_q, timer_d;
    logic [31:0] batches_q, batches_d;
    logic [31:0] timeouts_q, timeouts_d;
    logic [31:0] txns_q, txns_d;

    logic timeout_hit, s_fire, m_fire, in_drain, last_beat;
    txn_t wr_txn, rd_txn;

    assign timeout_hit   = (count_q != 8'd0) && (timer_q >= TMO_C);
    assign s_axis_tready = (state_q == ST_COLLECT) && (count_q < MAX_C) && !timeout_hit;
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    assign in_drain  = (state_q == ST_DRAIN);
    assign last_beat = (rd_ptr_q == count_q - 8'd1);
    assign m_fire    = in_drain && m_axis_tready;

    assign wr_txn = {s_axis_tdata_owner_programID,
                     s_axis_tdata_read_dependencies,
                     s_axis_tdata_write_dependencies};

    batch_buffer #(
        .DEPTH (MAX_BATCH_SIZE),
        .AW    (AW)
    ) u_buffer (
        .clk       (clk),
        .wr_en_i   (s_fire),
        .wr_addr_i (count_q[AW-1:0]),
        .wr_data_i (wr_txn),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_txn)
    );

    // Data is gated by DRAIN so the un-reset buffer never shows on the outputs.
    assign m_axis_tvalid                   = in_drain;
    assign m_axis_tlast                    = in_drain && last_beat;
    assign m_axis_tdata_owner_programID    = in_drain ? rd_txn.programID  : '0;
    assign m_axis_tdata_read_dependencies  = in_drain ? rd_txn.read_deps  : '0;
    assign m_axis_tdata_write_dependencies = in_drain ? rd_txn.write_deps : '0;
    assign batch_completed                 = (state_q == ST_DONE);

    assign batch_fill     = count_q;
    assign batches_issued = batches_q;
    assign timeout_closes = timeouts_q;
    assign txns_issued    = txns_q;

    // Next-state logic for the COLLECT / DRAIN / DONE batch cycle.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        timer_d    = timer_q;
        batches_d  = batches_q;
        timeouts_d = timeouts_q;
        txns_d     = txns_q;
        case (state_q)
            ST_COLLECT: begin
                if (s_fire) begin
                    count_d = count_q + 8'd1;
                end
                if (count_q == 8'd0) begin
                    timer_d = '0;
                end else if (timer_q < TMO_C) begin
                    timer_d = timer_q + 16'd1;
                end
                if ((count_q == MAX_C) || timeout_hit) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                    if (timeout_hit && (count_q < MAX_C)) begin
                        timeouts_d = timeouts_q + 32'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (m_fire) begin
                    rd_ptr_d = rd_ptr_q + 8'd1;
                    txns_d   = txns_q + 32'd1;
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                batches_d = batches_q + 32'd1;
                count_d   = '0;
                rd_ptr_d  = '0;
                timer_d   = '0;
                state_d   = ST_COLLECT;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            timer_q    <= '0;
            batches_q  <= '0;
            timeouts_q <= '0;
            txns_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            timer_q    <= timer_d;
            batches_q  <= batches_d;
            timeouts_q <= timeouts_d;
            txns_q     <= txns_d;
        end
    end

endmodule

// File: tb/tb_batch_assembler.sv
// Self-checking bench for batch_assembler (MAX_BATCH_SIZE=4, BATCH_TIMEOUT=16)
// against a queue-based reference model.
module tb_batch_assembler;
    import svm_sched_pkg::*;

    localparam int MB = 4;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [PID_WIDTH-1:0] s_axis_tdata_owner_programID;
    logic [DEP_WIDTH-1:0] s_axis_tdata_read_dependencies;
    logic [DEP_WIDTH-1:0] s_axis_tdata_write_dependencies;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [PID_WIDTH-1:0] m_axis_tdata_owner_programID;
    logic [DEP_WIDTH-1:0] m_axis_tdata_read_dependencies;
    logic [DEP_WIDTH-1:0] m_axis_tdata_write_dependencies;
    logic                 m_axis_tlast;
    logic                 batch_completed;
    logic [7:0]           batch_fill;
    logic [31:0]          batches_issued;
    logic [31:0]          timeout_closes;
    logic [31:0]          txns_issued;

    always #5 clk = ~clk;

    batch_assembler #(
        .MAX_BATCH_SIZE (MB),
        .BATCH_TIMEOUT  (TO)
    ) dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .s_axis_tvalid                   (s_axis_tvalid),
        .s_axis_tready                   (s_axis_tready),
        .s_axis_tdata_owner_programID    (s_axis_tdata_owner_programID),
        .s_axis_tdata_read_dependencies  (s_axis_tdata_read_dependencies),
        .s_axis_tdata_write_dependencies (s_axis_tdata_write_dependencies),
        .m_axis_tvalid                   (m_axis_tvalid),
        .m_axis_tready                   (m_axis_tready),
        .m_axis_tdata_owner_programID    (m_axis_tdata_owner_programID),
        .m_axis_tdata_read_dependencies  (m_axis_tdata_read_dependencies),
        .m_axis_tdata_write_dependencies (m_axis_tdata_write_dependencies),
        .m_axis_tlast                    (m_axis_tlast),
        .batch_completed                 (batch_completed),
        .batch_fill                      (batch_fill),
        .batches_issued                  (batches_issued),
        .timeout_closes                  (timeout_closes),
        .txns_issued                     (txns_issued)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending upstream items, current batch contents, phase.
    txn_t        src_q[$];
    txn_t        batch_q[$];
    int          m_phase;   // 0 collecting, 1 draining, 2 completion cycle
    int          m_age;     // cycles since first accepted entry, saturating
    int          m_beat;    // index of the entry currently offered downstream
    logic [31:0] m_batches, m_timeouts, m_txns;
    int          vmode, rmode;
    logic        tog;
    int          beat_cnt, last_len;

    function automatic txn_t mk(input logic [63:0] id);
        txn_t t;
        t.programID = id;
        for (int i = 0; i < 32; i++) begin
            t.read_deps[i*32 +: 32]  = $urandom;
            t.write_deps[i*32 +: 32] = $urandom;
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int w;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            w = 0;
            for (int i = 31; i >= 0; i--) begin
                if (obs[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
            end
            $error("FAIL %s: word %0d observed %h expected %h", tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    task automatic mdl_reset();
        batch_q.delete();
        m_phase = 0; m_age = 0; m_beat = 0;
        m_batches = '0; m_timeouts = '0; m_txns = '0;
        beat_cnt = 0; last_len = 0;
    endtask

    // One clock: drive inputs, compare against the model, advance at the edge.
    task automatic cycle();
        logic exp_ready, acc, mfire, is_last, closing;
        int   fill;
        fill = batch_q.size();
        if (src_q.size() > 0) begin
            s_axis_tdata_owner_programID    = src_q[0].programID;
            s_axis_tdata_read_dependencies  = src_q[0].read_deps;
            s_axis_tdata_write_dependencies = src_q[0].write_deps;
            case (vmode)
                0:       s_axis_tvalid = 1'b1;
                1:       s_axis_tvalid = 1'($urandom_range(0, 1));
                default: s_axis_tvalid = (fill < 2) || (m_age == TO - 1);
            endcase
        end else begin
            s_axis_tvalid = 1'b0;
        end
        case (rmode)
            0:       m_axis_tready = 1'b1;
            1:       begin m_axis_tready = tog; tog = ~tog; end
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        #1;
        exp_ready = (m_phase == 0) && (fill < MB) && !(fill > 0 && m_age >= TO);
        is_last   = (m_phase == 1) && (m_beat == fill - 1);
        chk("s_tready", 64'(s_axis_tready), 64'(exp_ready));
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(m_phase == 1));
        chk("m_tlast", 64'(m_axis_tlast), 64'(is_last));
        chk("batch_completed", 64'(batch_completed), 64'(m_phase == 2));
        chk("batch_fill", 64'(batch_fill), 64'(fill));
        chk("batches_issued", 64'(batches_issued), 64'(m_batches));
        chk("timeout_closes", 64'(timeout_closes), 64'(m_timeouts));
        chk("txns_issued", 64'(txns_issued), 64'(m_txns));
        if (m_phase == 1) begin
            chk("m_pid", m_axis_tdata_owner_programID, batch_q[m_beat].programID);
            chk_wide("m_rdeps", m_axis_tdata_read_dependencies, batch_q[m_beat].read_deps);
            chk_wide("m_wdeps", m_axis_tdata_write_dependencies, batch_q[m_beat].write_deps);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beat_cnt++;
            if (m_axis_tlast) begin
                last_len = beat_cnt;
                beat_cnt = 0;
            end
        end
        acc   = s_axis_tvalid && exp_ready;
        mfire = (m_phase == 1) && m_axis_tready;
        @(posedge clk);
        case (m_phase)
            0: begin
                closing = (fill == MB) || (fill > 0 && m_age >= TO);
                if (closing && fill < MB) m_timeouts++;
                if (fill == 0 || closing) m_age = 0;
                else if (m_age < TO) m_age++;
                if (acc) batch_q.push_back(src_q.pop_front());
                if (closing) m_phase = 1;
            end
            1: begin
                if (mfire) begin
                    m_txns++;
                    if (is_last) m_phase = 2;
                    else m_beat++;
                end
            end
            default: begin
                m_batches++;
                batch_q.delete();
                m_beat  = 0;
                m_phase = 0;
            end
        endcase
        #1;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((src_q.size() > 0 || batch_q.size() > 0 || m_phase != 0) && n < budget) begin
            cycle();
            n++;
        end
        n_cmp++;
        assert (n < budget) else begin
            n_err++;
            $error("FAIL %s_budget: observed %0d cycles expected below %0d", tag, n, budget);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tdata_owner_programID    = '0;
        s_axis_tdata_read_dependencies  = '0;
        s_axis_tdata_write_dependencies = '0;
        vmode = 0; rmode = 0; tog = 1'b1;
        mdl_reset();
        #1;
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_completed", 64'(batch_completed), 64'd0);
        chk("rst_fill", 64'(batch_fill), 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
        chk("rst_m_pid", m_axis_tdata_owner_programID, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back full batch, IDs 1..4.
        for (int i = 1; i <= 4; i++) src_q.push_back(mk(64'(i)));
        run_until_idle("b2b", 100);
        chk("b2b_batches", 64'(batches_issued), 64'd1);
        chk("b2b_txns", 64'(txns_issued), 64'd4);
        chk("b2b_len", 64'(last_len), 64'd4);

        // Single entry closed by timeout.
        src_q.push_back(mk(64'd7));
        run_until_idle("tmo", 100);
        chk("tmo_closes", 64'(timeout_closes), 64'd1);
        chk("tmo_len", 64'(last_len), 64'd1);

        // Full batch with downstream ready toggling.
        rmode = 1;
        for (int i = 10; i <= 13; i++) src_q.push_back(mk(64'(i)));
        run_until_idle("stall", 100);
        chk("stall_len", 64'(last_len), 64'd4);
        chk("stall_txns", 64'(txns_issued), 64'd9);
        rmode = 0;

        // Upstream held valid through DRAIN/DONE; 5th item starts batch 2.
        for (int i = 20; i <= 24; i++) src_q.push_back(mk(64'(i)));
        run_until_idle("hold", 150);
        chk("hold_batches", 64'(batches_issued), 64'd5);
        chk("hold_len", 64'(last_len), 64'd1);

        // Third entry accepted in the same cycle the timer reaches the limit.
        vmode = 2;
        for (int i = 30; i <= 32; i++) src_q.push_back(mk(64'(i)));
        run_until_idle("edge", 100);
        chk("edge_len", 64'(last_len), 64'd3);
        chk("edge_closes", 64'(timeout_closes), 64'd3);
        vmode = 0;

        // Randomized traffic.
        vmode = 1; rmode = 2;
        for (int i = 0; i < 40; i++) src_q.push_back(mk({32'h0, $urandom}));
        run_until_idle("rand", 3000);
        vmode = 0; rmode = 0;

        // Reset after the 2nd drained beat.
        for (int i = 40; i <= 43; i++) src_q.push_back(mk(64'(i)));
        n = 0;
        while (!(m_phase == 1 && m_beat == 2) && n < 50) begin
            cycle();
            n++;
        end
        chk("mid_reach", 64'(n < 50), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mid_completed", 64'(batch_completed), 64'd0);
        chk("mid_fill", 64'(batch_fill), 64'd0);
        chk("mid_batches", 64'(batches_issued), 64'd0);
        chk("mid_closes", 64'(timeout_closes), 64'd0);
        chk("mid_txns", 64'(txns_issued), 64'd0);
        chk("mid_m_pid", m_axis_tdata_owner_programID, 64'd0);
        chk_wide("mid_m_rdeps", m_axis_tdata_read_dependencies, '0);
        src_q.delete();
        mdl_reset();
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        chk("mid_completed_held", 64'(batch_completed), 64'd0);
        #1;
        rst_n = 1'b1;

        // Recovery after reset.
        for (int i = 50; i <= 51; i++) src_q.push_back(mk(64'(i)));
        run_until_idle("post", 100);
        chk("post_batches", 64'(batches_issued), 64'd1);
        chk("post_txns", 64'(txns_issued), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
